rng_bit_fifo: RTL and testbench

- Collects a serial stream of random bits, one per enabled clock, into a 256-bit shift buffer.
- Reports how many whole bytes are buffered.
- Presents a 32-bit word to the consumer; a single-cycle read strobe destructively consumes one 32-bit word.
- Sits between the entropy-source bit generator and the bus-side register interface of the RNG.

---
 rtl/rng_bit_fifo_pkg.sv | 18 +
 rtl/rng_bit_fifo_word_window_mux.sv | 26 ++
 rtl/rng_bit_fifo.sv | 74 +++++++
 tb/tb_rng_bit_fifo.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rng_bit_fifo_pkg.sv
// Shared constants for the RNG bit FIFO.
//   DATA_W    : width of the word presented to and consumed by the bus side
//   BUF_BITS  : depth of the shift buffer in bits
//   CNT_W     : width of the valid-bit counter (log2 of BUF_BITS)
//   BYTES_W   : width of the bytes-ready report (CNT_W - 3)
//   WORD_BITS : bits removed from the count by one read
package rng_bit_fifo_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BUF_BITS  = 256;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned BYTES_W   = CNT_W - 3;
  localparam int unsigned WORD_BITS = 32;

  localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

endpackage

// File: rtl/rng_bit_fifo_word_window_mux.sv
// Variable-offset word select from the shift buffer.
// Ports:
//   sr_i   : shift buffer contents, newest bit at bit 0
//   cnt_i  : number of valid bits in the buffer
//   word_o : oldest unread word sr[cnt-1 -: DATA_W] when at least one whole
//            word is buffered, otherwise the bottom DATA_W bits of the buffer
module rng_bit_fifo_word_window_mux
  import rng_bit_fifo_pkg::*;
(
  input  logic [BUF_BITS-1:0] sr_i,
  input  logic [CNT_W-1:0]    cnt_i,
  output logic [DATA_W-1:0]   word_o
);

  logic [CNT_W-1:0]    offset;
  logic [BUF_BITS-1:0] shifted;

  always_comb begin
    // The oldest unread word starts WORD_BITS below the count; below one word
    // the window is pinned at the bottom of the buffer.
    offset  = (cnt_i >= WORD_CNT) ? (cnt_i - WORD_CNT) : '0;
    shifted = sr_i >> offset;
    word_o  = shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/rng_bit_fifo.sv
// Serial random-bit collector feeding the RNG bus-side register interface.
// Bits enter a BUF_BITS-deep shift buffer one per enabled clock; a read strobe
// consumes one DATA_W word per high cycle, or flushes the buffer when less than
// a whole word is held.
// Ports:
//   i_clock      : system clock, rising-edge active
//   i_rst        : asynchronous active-high reset
//   i_enb        : shift enable, captures i_ranBit on this edge
//   i_ranBit     : random bit to capture
//   i_read       : read strobe, one word consumed per high cycle
//   o_data       : oldest unread word (or buffer bottom when under one word)
//   o_bytesReady : whole bytes buffered, the count divided by eight
module rng_bit_fifo
  import rng_bit_fifo_pkg::*;
(
  input  logic               i_clock,
  input  logic               i_rst,
  input  logic               i_enb,
  input  logic               i_ranBit,
  input  logic               i_read,
  output logic [DATA_W-1:0]  o_data,
  output logic [BYTES_W-1:0] o_bytesReady
);

  logic [BUF_BITS-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    shift_inc;
  logic                flush;

  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    shift_inc = CNT_W'(i_enb);
    flush     = i_read && (cnt_q < WORD_CNT);

    if (flush) begin
      // Partial or empty word: discard everything, keep only this edge's bit.
      sr_d    = '0;
      sr_d[0] = i_enb & i_ranBit;
      cnt_d   = shift_inc;
    end else begin
      // Collection never stalls for reads.
      if (i_enb) begin
        sr_d = {sr_q[BUF_BITS-2:0], i_ranBit};
      end
      if (i_read) begin
        // cnt >= WORD_CNT here, so no underflow; max result is 224.
        cnt_d = cnt_q - WORD_CNT + shift_inc;
      end else if (i_enb && (cnt_q != CNT_MAX)) begin
        // At full count the bit still shifts in and the oldest is lost.
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  rng_bit_fifo_word_window_mux u_word_window_mux (
    .sr_i   (sr_q),
    .cnt_i  (cnt_q),
    .word_o (o_data)
  );

  assign o_bytesReady = cnt_q[CNT_W-1:3];

endmodule

// File: tb/tb_rng_bit_fifo.sv
// Self-checking bench for rng_bit_fifo: directed scenarios followed by
// randomized segments, all compared against a bit-history queue model.
module tb_rng_bit_fifo;

  logic        clk;
  logic        i_rst;
  logic        i_enb;
  logic        i_ranBit;
  logic        i_read;
  logic [31:0] o_data;
  logic [4:0]  o_bytesReady;

  int n_checks;
  int n_fail;

  // Model: every bit captured since the last reset/flush, oldest first,
  // holding at most the 256 most recent; m_cnt is the valid-bit count.
  bit hist[$];
  int m_cnt;

  rng_bit_fifo dut (
    .i_clock      (clk),
    .i_rst        (i_rst),
    .i_enb        (i_enb),
    .i_ranBit     (i_ranBit),
    .i_read       (i_read),
    .o_data       (o_data),
    .o_bytesReady (o_bytesReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    hist.delete();
    m_cnt = 0;
  endfunction

  function automatic void model_step(input bit enb, input bit b, input bit rd);
    if (rd && m_cnt < 32) begin
      hist.delete();
      if (enb) hist.push_back(b);
      m_cnt = enb ? 1 : 0;
    end else begin
      if (enb) begin
        hist.push_back(b);
        if (hist.size() > 256) void'(hist.pop_front());
      end
      if (rd) m_cnt = m_cnt - 32 + (enb ? 1 : 0);
      else if (enb && m_cnt < 255) m_cnt = m_cnt + 1;
    end
  endfunction

  // Word bit k is the bit captured (base + k) captures ago, counting the
  // newest as zero; base selects the oldest unread word when one exists.
  function automatic logic [31:0] model_word();
    logic [31:0] w;
    int base;
    int idx;
    w    = '0;
    base = (m_cnt >= 32) ? m_cnt - 32 : 0;
    for (int k = 0; k < 32; k++) begin
      idx = hist.size() - 1 - (base + k);
      if (idx >= 0) w[k] = hist[idx];
    end
    return w;
  endfunction

  task automatic step(input bit enb, input bit b, input bit rd);
    i_enb    = enb;
    i_ranBit = b;
    i_read   = rd;
    @(posedge clk);
    model_step(enb, b, rd);
    #1;
    check("bytes_ready", 32'(o_bytesReady), 32'(m_cnt / 8));
    check("data", o_data, model_word());
    i_enb  = 1'b0;
    i_read = 1'b0;
  endtask

  task automatic run(input int n, input bit enb, input bit b, input bit rd);
    for (int i = 0; i < n; i++) step(enb, b, rd);
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic async_reset();
    #2;
    i_rst = 1'b1;
    #1;
    model_clear();
    check("rst_bytes_ready", 32'(o_bytesReady), 32'd0);
    check("rst_data", o_data, 32'd0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    logic [31:0] pattern;
    int          read_pct;
    int          enb_pct;

    n_checks = 0;
    n_fail   = 0;
    i_rst    = 1'b1;
    i_enb    = 1'b0;
    i_ranBit = 1'b0;
    i_read   = 1'b0;
    model_clear();

    #1;
    check("reset_bytes_ready", 32'(o_bytesReady), 32'd0);
    check("reset_data", o_data, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    i_rst = 1'b0;

    // Fill and count, then read at exactly one word.
    run(32, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);

    // Partial flush: 56 bits, consume one word, then flush the remainder.
    async_reset();
    run(56, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);

    // Saturation and a run of back-to-back reads from full.
    async_reset();
    run(300, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    run(32, 1'b1, 1'b1, 1'b0);
    run(8, 1'b1, 1'b0, 1'b1);

    // Data tracking through a flush with a zeros-only history.
    async_reset();
    run(8, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);

    // Oldest-word window.
    async_reset();
    pattern = 32'hA5A5_0F0F;
    for (int i = 31; i >= 0; i--) step(1'b1, pattern[i], 1'b0);
    run(8, 1'b1, 1'b0, 1'b0);
    check("window_word", o_data, 32'hA5A5_0F0F);
    step(1'b1, 1'b0, 1'b1);

    // Enable low freezes everything, except that a read still acts.
    run(20, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    run(40, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    // Randomized segments with varying read and enable densities.
    for (int seg = 0; seg < 14; seg++) begin
      read_pct = $urandom_range(0, 40);
      enb_pct  = $urandom_range(50, 100);
      for (int c = 0; c < 250; c++) begin
        step(($urandom_range(0, 99) < enb_pct) ? 1'b1 : 1'b0,
             1'($urandom),
             ($urandom_range(0, 99) < read_pct) ? 1'b1 : 1'b0);
      end
      if (seg % 4 == 3) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
